// File: rtl/text_pkg.sv
// Shared geometry, character ids and control codes for the 15x40 text plane,
// its renderer and the cursor writer.
package text_pkg;

   localparam int ROWS   = 15;
   localparam int COLS   = 40;
   localparam int ROW_W  = 4;
   localparam int COL_W  = 6;
   localparam int CHAR_W = 8;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   localparam logic [CHAR_W-1:0] BLANK     = 8'h20;
   localparam logic [CHAR_W-1:0] CC_BS     = 8'h08;
   localparam logic [CHAR_W-1:0] CC_LF     = 8'h0A;
   localparam logic [CHAR_W-1:0] CC_FF     = 8'h0C;
   localparam logic [CHAR_W-1:0] CC_CR     = 8'h0D;
   localparam logic [CHAR_W-1:0] PRINT_MIN = 8'h20;
   localparam logic [CHAR_W-1:0] PRINT_MAX = 8'h7E;

   // Moves a grid_counter can make on one clock edge
   typedef enum logic [2:0] {
      GOP_HOLD,
      GOP_INC,
      GOP_DEC,
      GOP_ZERO,
      GOP_CR,
      GOP_LF
   } grid_op_t;

endpackage

// File: rtl/grid_counter.sv
// Row-major position counter over the text plane. Wraps at both ends and
// exposes the previous cell so a caller can address it before stepping back.
module grid_counter
   import text_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  grid_op_t         op,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] prev_row,
   output logic [COL_W-1:0] prev_col,
   output logic             at_first,
   output logic             at_last
);

   logic [ROW_W-1:0] next_row;
   logic [COL_W-1:0] next_col;
   logic [ROW_W-1:0] row_plus;

   assign at_first = (row == '0) && (col == '0);
   assign at_last  = (row == ROW_LAST) && (col == COL_LAST);
   assign row_plus = (row == ROW_LAST) ? '0 : row + 1'b1;

   always_comb begin
      prev_row = row;
      prev_col = col - 1'b1;
      if (col == '0) begin
         prev_col = COL_LAST;
         prev_row = (row == '0) ? ROW_LAST : row - 1'b1;
      end
   end

   always_comb begin
      next_row = row;
      next_col = col;
      case (op)
         GOP_INC: begin
            if (col == COL_LAST) begin
               next_col = '0;
               next_row = row_plus;
            end else begin
               next_col = col + 1'b1;
            end
         end
         GOP_DEC: begin
            next_row = prev_row;
            next_col = prev_col;
         end
         GOP_ZERO: begin
            next_row = '0;
            next_col = '0;
         end
         GOP_CR: next_col = '0;
         GOP_LF: begin
            next_col = '0;
            next_row = row_plus;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row <= '0;
         col <= '0;
      end else begin
         row <= next_row;
         col <= next_col;
      end
   end

endmodule

// File: rtl/text_cursor_writer.sv
// Terminal-style writer: turns a char stream into cell writes on the text plane,
// keeping a cursor, handling BS/CR/LF/FF and walking a full-screen clear.
module text_cursor_writer
   import text_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
)
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [CHAR_W-1:0] char_in,
   input  logic              char_valid,
   output logic              char_ready,
   output logic [CHAR_W-1:0] wr_data,
   output logic [ROW_W-1:0]  wr_row,
   output logic [COL_W-1:0]  wr_col,
   output logic              wr_en,
   output logic [ROW_W-1:0]  cursor_row,
   output logic [COL_W-1:0]  cursor_col
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;
   localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   logic [0:0]        state;
   logic [0:0]        state_next;
   grid_op_t          cur_op;
   grid_op_t          clr_op;
   logic              accept;
   logic              wr_next;
   logic [CHAR_W-1:0] data_next;
   logic [ROW_W-1:0]  row_next;
   logic [COL_W-1:0]  col_next;

   logic [ROW_W-1:0]  cur_prev_row;
   logic [COL_W-1:0]  cur_prev_col;
   logic              cur_at_first;
   logic              cur_at_last;
   logic [ROW_W-1:0]  clr_row;
   logic [COL_W-1:0]  clr_col;
   logic [ROW_W-1:0]  clr_prev_row;
   logic [COL_W-1:0]  clr_prev_col;
   logic              clr_at_first;
   logic              clr_at_last;

   grid_counter u_cursor (
      .clock    (clock),
      .reset_n  (reset_n),
      .op       (cur_op),
      .row      (cursor_row),
      .col      (cursor_col),
      .prev_row (cur_prev_row),
      .prev_col (cur_prev_col),
      .at_first (cur_at_first),
      .at_last  (cur_at_last)
   );

   grid_counter u_clear (
      .clock    (clock),
      .reset_n  (reset_n),
      .op       (clr_op),
      .row      (clr_row),
      .col      (clr_col),
      .prev_row (clr_prev_row),
      .prev_col (clr_prev_col),
      .at_first (clr_at_first),
      .at_last  (clr_at_last)
   );

   assign char_ready = (state == ST_IDLE);
   assign accept     = char_valid & char_ready;

   // Backspace writes at the cell it steps back to, not at the current cursor
   always_comb begin
      state_next = state;
      cur_op     = GOP_HOLD;
      clr_op     = GOP_HOLD;
      wr_next    = 1'b0;
      data_next  = BLANK;
      row_next   = cursor_row;
      col_next   = cursor_col;
      if (state == ST_CLEAR) begin
         wr_next  = 1'b1;
         row_next = clr_row;
         col_next = clr_col;
         clr_op   = GOP_INC;
         if (clr_at_last) state_next = ST_IDLE;
      end else if (accept) begin
         if ((char_in >= PRINT_MIN) && (char_in <= PRINT_MAX)) begin
            wr_next   = 1'b1;
            data_next = char_in;
            cur_op    = GOP_INC;
         end else begin
            case (char_in)
               CC_BS: begin
                  if (!cur_at_first) begin
                     wr_next  = 1'b1;
                     row_next = cur_prev_row;
                     col_next = cur_prev_col;
                     cur_op   = GOP_DEC;
                  end
               end
               CC_CR: cur_op = GOP_CR;
               CC_LF: cur_op = GOP_LF;
               CC_FF: begin
                  cur_op     = GOP_ZERO;
                  clr_op     = GOP_ZERO;
                  state_next = ST_CLEAR;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_RESET;
         wr_en   <= 1'b0;
         wr_data <= '0;
         wr_row  <= '0;
         wr_col  <= '0;
      end else begin
         state <= state_next;
         wr_en <= wr_next;
         if (wr_next) begin
            wr_data <= data_next;
            wr_row  <= row_next;
            wr_col  <= col_next;
         end
      end
   end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Self-checking bench for text_cursor_writer: reset clear walk, back-to-back
// writes, a table of cursor corner cases, random chars against a linear-position model.
module tb_text_cursor_writer;
   import text_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic [7:0] wr_data;
   logic [3:0] wr_row;
   logic [5:0] wr_col;
   logic       wr_en;
   logic [3:0] cursor_row;
   logic [5:0] cursor_col;

   int checks = 0;
   int failures = 0;
   int modelPos = 0;

   typedef struct {
      string      name;
      int         startRow;
      int         startCol;
      logic [7:0] code;
      bit         expWr;
      int         expRow;
      int         expCol;
      logic [7:0] expData;
      int         expCurRow;
      int         expCurCol;
   } vec_t;

   vec_t vecs[11];

   always #5 clock = ~clock;

   text_cursor_writer #(.CLEAR_ON_RESET(1'b1)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .wr_data    (wr_data),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_en      (wr_en),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col)
   );

   function automatic vec_t mkVec(input string n, input int sr, input int sc, input logic [7:0] code,
                                  input bit w, input int r, input int c, input logic [7:0] d,
                                  input int cr, input int cc);
      vec_t v;
      v.name = n; v.startRow = sr; v.startCol = sc; v.code = code; v.expWr = w;
      v.expRow = r; v.expCol = c; v.expData = d; v.expCurRow = cr; v.expCurCol = cc;
      return v;
   endfunction

   task automatic compareVal(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input bit expWr, input int expRow, input int expCol,
                              input logic [7:0] expData, input int expCurRow, input int expCurCol);
      compareVal({name, " wr_en"}, int'(wr_en), int'(expWr));
      if (expWr) begin
         compareVal({name, " wr_row"}, int'(wr_row), expRow);
         compareVal({name, " wr_col"}, int'(wr_col), expCol);
         compareVal({name, " wr_data"}, int'(wr_data), int'(expData));
      end
      compareVal({name, " cursor_row"}, int'(cursor_row), expCurRow);
      compareVal({name, " cursor_col"}, int'(cursor_col), expCurCol);
   endtask

   // Reference: cursor as a linear cell index 0..ROWS*COLS-1
   task automatic modelStep(input logic [7:0] c, output bit expWr, output int expRow, output int expCol,
                            output logic [7:0] expData, output bit isFF);
      int r;
      int k;
      r = modelPos / 40;
      k = modelPos % 40;
      expWr = 0; expRow = 0; expCol = 0; expData = 8'h20; isFF = 0;
      if (c >= 8'h20 && c <= 8'h7E) begin
         expWr = 1; expRow = r; expCol = k; expData = c;
         modelPos = (modelPos + 1) % 600;
      end else if (c == 8'h08) begin
         if (modelPos > 0) begin
            modelPos = modelPos - 1;
            expWr = 1; expRow = modelPos / 40; expCol = modelPos % 40;
         end
      end else if (c == 8'h0D) begin
         modelPos = r * 40;
      end else if (c == 8'h0A) begin
         modelPos = ((r + 1) % 15) * 40;
      end else if (c == 8'h0C) begin
         modelPos = 0;
         isFF = 1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] c);
      int waitCnt = 0;
      @(negedge clock);
      while (!char_ready && waitCnt < 2000) begin
         @(negedge clock);
         waitCnt++;
      end
      if (!char_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_timeout actual=0 expected=1");
         return;
      end
      char_in = c;
      char_valid = 1'b1;
      @(negedge clock);
      char_valid = 1'b0;
   endtask

   task automatic expectClear(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         compareVal({name, " wr_en"}, int'(wr_en), 1);
         compareVal({name, " cell"}, int'(wr_row) * 40 + int'(wr_col), i);
         compareVal({name, " data"}, int'(wr_data), 32);
         compareVal({name, " ready"}, int'(char_ready), (i == 599) ? 1 : 0);
         compareVal({name, " cursor"}, int'(cursor_row) * 40 + int'(cursor_col), 0);
         if (i == 599) char_valid = 1'b0;
      end
   endtask

   task automatic sendModel(input string name, input logic [7:0] c);
      bit w;
      bit isFF;
      int r;
      int k;
      logic [7:0] d;
      applyStimulus(c);
      modelStep(c, w, r, k, d, isFF);
      checkOutput(name, w, r, k, d, modelPos / 40, modelPos % 40);
      if (isFF) begin
         compareVal({name, " ff ready"}, int'(char_ready), 0);
         expectClear({name, " clr"}, 600);
      end
   endtask

   task automatic moveCursor(input int r, input int c);
      sendModel("mv cr", 8'h0D);
      while (modelPos / 40 != r) sendModel("mv lf", 8'h0A);
      repeat (c) sendModel("mv chr", 8'h2E);
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit w;
      bit isFF;
      int r;
      int k;
      int pick;
      logic [7:0] d;
      logic [7:0] code;

      vecs[0]  = mkVec("wrap col",   0, 39, 8'h42, 1,  0, 39, 8'h42, 1, 0);
      vecs[1]  = mkVec("wrap end",  14, 39, 8'h5A, 1, 14, 39, 8'h5A, 0, 0);
      vecs[2]  = mkVec("bs col0",    2,  0, 8'h08, 1,  1, 39, 8'h20, 1, 39);
      vecs[3]  = mkVec("bs origin",  0,  0, 8'h08, 0,  0,  0, 8'h00, 0, 0);
      vecs[4]  = mkVec("cr",         3, 17, 8'h0D, 0,  0,  0, 8'h00, 3, 0);
      vecs[5]  = mkVec("lf wrap",   14,  5, 8'h0A, 0,  0,  0, 8'h00, 0, 0);
      vecs[6]  = mkVec("bell",       4,  9, 8'h07, 0,  0,  0, 8'h00, 4, 9);
      vecs[7]  = mkVec("print max",  5, 20, 8'h7E, 1,  5, 20, 8'h7E, 5, 21);
      vecs[8]  = mkVec("del",        6,  3, 8'h7F, 0,  0,  0, 8'h00, 6, 3);
      vecs[9]  = mkVec("print min",  7,  0, 8'h20, 1,  7,  0, 8'h20, 7, 1);
      vecs[10] = mkVec("bs mid",     1, 39, 8'h08, 1,  1, 38, 8'h20, 1, 38);

      // Reset values, then the power-up clear while a char is offered
      repeat (3) @(negedge clock);
      #1;
      checkOutput("reset", 0, 0, 0, 8'h00, 0, 0);
      compareVal("reset wr_en", int'(wr_en), 0);
      compareVal("reset wr_addr", int'(wr_row) * 40 + int'(wr_col), 0);
      compareVal("reset wr_data", int'(wr_data), 0);
      compareVal("reset ready", int'(char_ready), 0);
      @(negedge clock);
      reset_n = 1'b1;
      char_in = 8'h41;
      char_valid = 1'b1;
      expectClear("boot clr", 600);
      @(negedge clock);
      compareVal("boot after wr_en", int'(wr_en), 0);
      compareVal("boot after cursor", int'(cursor_row) * 40 + int'(cursor_col), 0);
      modelPos = 0;

      // Back-to-back "ABC"
      char_in = 8'h41;
      char_valid = 1'b1;
      @(negedge clock);
      checkOutput("b2b A", 1, 0, 0, 8'h41, 0, 1);
      compareVal("b2b ready", int'(char_ready), 1);
      char_in = 8'h42;
      @(negedge clock);
      checkOutput("b2b B", 1, 0, 1, 8'h42, 0, 2);
      char_in = 8'h43;
      @(negedge clock);
      char_valid = 1'b0;
      checkOutput("b2b C", 1, 0, 2, 8'h43, 0, 3);
      @(negedge clock);
      compareVal("b2b idle wr_en", int'(wr_en), 0);
      modelPos = 3;

      for (int i = 0; i < 11; i++) begin
         moveCursor(vecs[i].startRow, vecs[i].startCol);
         applyStimulus(vecs[i].code);
         checkOutput(vecs[i].name, vecs[i].expWr, vecs[i].expRow, vecs[i].expCol,
                     vecs[i].expData, vecs[i].expCurRow, vecs[i].expCurCol);
         modelStep(vecs[i].code, w, r, k, d, isFF);
      end

      for (int i = 0; i < 400; i++) begin
         pick = $urandom_range(0, 99);
         if (pick < 60)      code = 8'($urandom_range(8'h20, 8'h7E));
         else if (pick < 72) code = 8'h08;
         else if (pick < 80) code = 8'h0D;
         else if (pick < 88) code = 8'h0A;
         else if (pick < 97) code = 8'($urandom_range(8'h7F, 8'hFF));
         else                code = 8'h0C;
         sendModel("rand", code);
      end

      // Form feed interrupted by reset halfway through the walk
      applyStimulus(8'h0C);
      modelStep(8'h0C, w, r, k, d, isFF);
      checkOutput("ff", 0, 0, 0, 8'h00, 0, 0);
      char_in = 8'h41;
      char_valid = 1'b1;
      expectClear("ff clr", 300);
      reset_n = 1'b0;
      #1;
      compareVal("mid rst wr_en", int'(wr_en), 0);
      compareVal("mid rst wr_addr", int'(wr_row) * 40 + int'(wr_col), 0);
      compareVal("mid rst wr_data", int'(wr_data), 0);
      compareVal("mid rst cursor", int'(cursor_row) * 40 + int'(cursor_col), 0);
      compareVal("mid rst ready", int'(char_ready), 0);
      @(negedge clock);
      reset_n = 1'b1;
      expectClear("restart clr", 600);
      @(negedge clock);
      compareVal("restart after wr_en", int'(wr_en), 0);
      compareVal("restart after cursor", int'(cursor_row) * 40 + int'(cursor_col), 0);
      modelPos = 0;
      sendModel("post", 8'h51);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
